// File: rtl/gpio_reg_file_if.sv
// Processor-side GPIO command/response bus and the log sample stream feeding the register file.
interface gpio_reg_file_if #(
    parameter int NB_GPIOS        = 32,
    parameter int NB_DATA_RAM_LOG = 16
);
    logic [NB_GPIOS-1:0]        gpo;
    logic [NB_GPIOS-1:0]        gpi;
    logic [NB_DATA_RAM_LOG-1:0] log_data;
    logic                       log_valid;

    modport master (
        output gpo,
        output log_data,
        output log_valid,
        input  gpi
    );

    modport slave (
        input  gpo,
        input  log_data,
        input  log_valid,
        output gpi
    );
endinterface

// File: rtl/gpio_reg_file.sv
// GPIO-mailbox register file: edge-triggered command FSM with ack handshake, LED/soft-reset
// control registers and a one-shot sample log readable through the same mailbox.
module gpio_reg_file #(
    parameter int NB_GPIOS        = 32,
    parameter int NB_LEDS         = 4,
    parameter int NB_DATA_RAM_LOG = 16,
    parameter int NB_ADDR_RAM_LOG = 10
) (
    input  logic               clock,
    input  logic               i_reset,
    gpio_reg_file_if.slave     bus,
    output logic [NB_LEDS-1:0] o_leds,
    output logic               o_soft_reset,
    output logic               o_log_full
);
    localparam int DEPTH   = 1 << NB_ADDR_RAM_LOG;
    localparam int NB_RESP = NB_GPIOS - 1;

    localparam logic [7:0] CMD_SOFT_RST = 8'h01;
    localparam logic [7:0] CMD_SET_LEDS = 8'h02;
    localparam logic [7:0] CMD_LOG_RUN  = 8'h03;
    localparam logic [7:0] CMD_LOG_READ = 8'h04;
    localparam logic [7:0] CMD_STATUS   = 8'h05;

    typedef enum logic [2:0] {IDLE, DECODE, MEM_RD, RESP, WAIT_LOW} state_t;

    state_t state, state_next;

    logic [NB_GPIOS-1:0]        gpo_q;
    logic [NB_GPIOS-1:0]        cmd_word;
    logic [NB_GPIOS-1:0]        gpi_q;
    logic                       en_prev;
    logic                       armed;
    logic                       running;
    logic                       cmd_error;
    logic [NB_ADDR_RAM_LOG-1:0] ptr;
    logic [NB_DATA_RAM_LOG-1:0] mem [DEPTH];
    logic [NB_DATA_RAM_LOG-1:0] rd_data;

    logic [7:0]         cmd;
    logic [22:0]        payload;
    logic               cmd_known;
    logic               en_rise;
    logic               accept;
    logic               exec;
    logic               rd_en;
    logic               set_ack;
    logic               clr_ack;
    logic               wr_en;
    logic               wr_last;
    logic [NB_RESP-1:0] resp_data;
    logic               unused_cmd_bits;

    assign cmd             = cmd_word[31:24];
    assign payload         = cmd_word[22:0];
    assign cmd_known       = (cmd >= CMD_SOFT_RST) && (cmd <= CMD_STATUS);
    assign en_rise         = gpo_q[23] & ~en_prev & armed;
    assign wr_en           = running & bus.log_valid;
    assign wr_last         = (ptr == {NB_ADDR_RAM_LOG{1'b1}});
    assign bus.gpi         = gpi_q;
    assign unused_cmd_bits = ^cmd_word;

    // armed stays low until a genuine low enable is registered, so an enable held
    // high across reset cannot masquerade as a fresh edge.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            gpo_q   <= '0;
            en_prev <= 1'b0;
            armed   <= 1'b0;
        end else begin
            gpo_q   <= bus.gpo;
            en_prev <= gpo_q[23];
            armed   <= armed | ~bus.gpo[23];
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        exec       = 1'b0;
        rd_en      = 1'b0;
        set_ack    = 1'b0;
        clr_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (en_rise) begin
                    accept     = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                exec       = 1'b1;
                state_next = (cmd == CMD_LOG_READ) ? MEM_RD : RESP;
            end
            MEM_RD: begin
                rd_en      = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                set_ack    = 1'b1;
                state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!gpo_q[23]) begin
                    clr_ack    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        resp_data = '0;
        case (cmd)
            CMD_LOG_READ: resp_data[NB_DATA_RAM_LOG-1:0]   = rd_data;
            CMD_STATUS:   resp_data[NB_ADDR_RAM_LOG+2:0]   = {cmd_error, o_log_full, running, ptr};
            default:      resp_data = '0;
        endcase
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            cmd_word     <= '0;
            gpi_q        <= '0;
            o_leds       <= '0;
            o_soft_reset <= 1'b0;
        end else begin
            if (accept) cmd_word <= gpo_q;
            if (exec) begin
                case (cmd)
                    CMD_SOFT_RST: o_soft_reset <= payload[0];
                    CMD_SET_LEDS: o_leds       <= payload[NB_LEDS-1:0];
                    default:      ;
                endcase
            end
            if (set_ack)      gpi_q <= {1'b1, resp_data};
            else if (clr_ack) gpi_q <= '0;
        end
    end

    // LOG_RUN overrides a capture write landing in the same cycle, restarting from zero.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            ptr        <= '0;
            running    <= 1'b0;
            o_log_full <= 1'b0;
            cmd_error  <= 1'b0;
        end else if (exec && cmd == CMD_LOG_RUN) begin
            ptr        <= '0;
            running    <= 1'b1;
            o_log_full <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            if (wr_en) begin
                ptr <= ptr + 1'b1;
                if (wr_last) begin
                    running    <= 1'b0;
                    o_log_full <= 1'b1;
                end
            end
            if (exec && !cmd_known) cmd_error <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[ptr] <= bus.log_data;
        if (rd_en) rd_data  <= mem[payload[NB_ADDR_RAM_LOG-1:0]];
    end
endmodule

// File: tb/tb_gpio_reg_file.sv
// Directed bench for gpio_reg_file: mailbox latency, LED/soft-reset control, log capture,
// overflow, read-first collision, enable edge rules and asynchronous reset abort.
module tb_gpio_reg_file;
    logic       clock;
    logic       i_reset;
    logic [3:0] leds;
    logic       soft_reset;
    logic       log_full;
    int         checks;
    int         failures;

    gpio_reg_file_if #(.NB_GPIOS(32), .NB_DATA_RAM_LOG(16)) bus ();

    gpio_reg_file #(
        .NB_GPIOS(32),
        .NB_LEDS(4),
        .NB_DATA_RAM_LOG(16),
        .NB_ADDR_RAM_LOG(3)
    ) dut (
        .clock(clock),
        .i_reset(i_reset),
        .bus(bus),
        .o_leds(leds),
        .o_soft_reset(soft_reset),
        .o_log_full(log_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Non-read commands ack 4 clocks after driving (1 register stage + 3), LOG_READ one later.
    task automatic apply_stimulus(input string tag, input logic [7:0] cmd, input logic [22:0] payload,
                                  input logic [31:0] expected);
        int lat;
        lat = (cmd == 8'h04) ? 5 : 4;
        bus.gpo = {cmd, 1'b1, payload};
        tick(lat - 1);
        check_output({tag, "_early"}, bus.gpi, 32'h0);
        tick(1);
        check_output(tag, bus.gpi, expected);
        bus.gpo = {cmd, 1'b0, payload};
        tick(2);
        check_output({tag, "_clear"}, bus.gpi, 32'h0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        i_reset       = 1'b1;
        bus.gpo       = '0;
        bus.log_data  = '0;
        bus.log_valid = 1'b0;
        tick(2);
        check_output("rst_gpi", bus.gpi, 32'h0);
        check_output("rst_leds", 32'(leds), 32'h0);
        check_output("rst_soft", 32'(soft_reset), 32'h0);
        check_output("rst_full", 32'(log_full), 32'h0);
        i_reset = 1'b0;
        tick(2);

        apply_stimulus("set_leds", 8'h02, 23'h5, 32'h8000_0000);
        check_output("leds_5", 32'(leds), 32'h5);
        apply_stimulus("soft_rst_on", 8'h01, 23'h1, 32'h8000_0000);
        check_output("soft_on", 32'(soft_reset), 32'h1);
        apply_stimulus("status_idle", 8'h05, 23'h0, 32'h8000_0000);

        apply_stimulus("log_run", 8'h03, 23'h0, 32'h8000_0000);
        for (int i = 0; i < 7; i++) begin
            bus.log_valid = 1'b1;
            bus.log_data  = 16'((i + 1) * 16'h11);
            tick(1);
        end
        check_output("full_after7", 32'(log_full), 32'h0);
        bus.log_data = 16'h0088;
        tick(1);
        bus.log_valid = 1'b0;
        check_output("full_after8", 32'(log_full), 32'h1);
        apply_stimulus("read5", 8'h04, 23'd5, 32'h8000_0066);

        for (int i = 0; i < 12; i++) begin
            bus.log_valid = 1'b1;
            bus.log_data  = 16'(16'h0F00 + i);
            tick(1);
        end
        bus.log_valid = 1'b0;
        apply_stimulus("read0_ovf", 8'h04, 23'd0, 32'h8000_0011);
        apply_stimulus("read7_ovf", 8'h04, 23'd7, 32'h8000_0088);
        apply_stimulus("status_full", 8'h05, 23'h0, 32'h8000_0010);

        apply_stimulus("unknown_7f", 8'h7F, 23'h1F, 32'h8000_0000);
        check_output("leds_kept", 32'(leds), 32'h5);
        apply_stimulus("status_err", 8'h05, 23'h0, 32'h8000_0030);
        apply_stimulus("log_run2", 8'h03, 23'h0, 32'h8000_0000);
        apply_stimulus("status_run", 8'h05, 23'h0, 32'h8000_0008);

        for (int i = 0; i < 3; i++) begin
            bus.log_valid = 1'b1;
            bus.log_data  = 16'((i + 1) * 16'h0101);
            tick(1);
        end
        bus.log_valid = 1'b0;
        apply_stimulus("status_ptr3", 8'h05, 23'h0, 32'h8000_000B);

        // Sample lands on address 3 in the very cycle the read of address 3 happens.
        bus.gpo = {8'h04, 1'b1, 23'd3};
        tick(3);
        bus.log_valid = 1'b1;
        bus.log_data  = 16'h0404;
        tick(1);
        bus.log_valid = 1'b0;
        tick(1);
        check_output("read_first", bus.gpi, 32'h8000_0044);
        bus.gpo = {8'h04, 1'b0, 23'd3};
        tick(2);
        apply_stimulus("read3_new", 8'h04, 23'd3, 32'h8000_0404);
        apply_stimulus("status_ptr4", 8'h05, 23'h0, 32'h8000_000C);
        check_output("soft_still_on", 32'(soft_reset), 32'h1);

        bus.gpo = {8'h02, 1'b1, 23'hA};
        tick(4);
        check_output("hold_ack", bus.gpi, 32'h8000_0000);
        check_output("hold_leds", 32'(leds), 32'hA);
        bus.gpo = {8'h02, 1'b1, 23'h6};
        tick(16);
        check_output("hold_ack20", bus.gpi, 32'h8000_0000);
        check_output("hold_once", 32'(leds), 32'hA);
        bus.gpo = '0;
        tick(2);
        check_output("hold_clear", bus.gpi, 32'h0);

        bus.gpo = {8'h02, 1'b1, 23'h3};
        tick(1);
        bus.gpo = {8'h02, 1'b0, 23'h3};
        tick(1);
        bus.gpo = {8'h02, 1'b1, 23'hC};
        tick(2);
        check_output("busy_ack", bus.gpi, 32'h8000_0000);
        tick(5);
        bus.gpo = '0;
        tick(2);
        check_output("busy_clear", bus.gpi, 32'h0);
        tick(3);
        check_output("busy_ignored", 32'(leds), 32'h3);
        check_output("busy_no_ack", bus.gpi, 32'h0);

        bus.gpo = {8'h04, 1'b1, 23'd0};
        tick(3);
        i_reset = 1'b1;
        #1;
        check_output("mrd_rst_gpi", bus.gpi, 32'h0);
        check_output("mrd_rst_leds", 32'(leds), 32'h0);
        check_output("mrd_rst_soft", 32'(soft_reset), 32'h0);
        check_output("mrd_rst_full", 32'(log_full), 32'h0);
        tick(1);
        i_reset = 1'b0;
        tick(6);
        check_output("held_after_rst", bus.gpi, 32'h0);
        bus.gpo = '0;
        tick(2);

        apply_stimulus("log_run3", 8'h03, 23'h0, 32'h8000_0000);
        bus.log_valid = 1'b1;
        bus.log_data  = 16'h0555;
        tick(2);
        i_reset = 1'b1;
        #1;
        check_output("cap_rst_gpi", bus.gpi, 32'h0);
        check_output("cap_rst_full", 32'(log_full), 32'h0);
        tick(1);
        i_reset = 1'b0;
        tick(1);
        bus.log_valid = 1'b0;
        tick(2);
        apply_stimulus("status_after_rst", 8'h05, 23'h0, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
